// File: rtl/seq_det_pkg.sv
// Shared types and constants for the arbitrated 1010 sequence detector.
package seq_det_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } ctrl_state_t;

    // Detector state k means the last k bits seen are the first k bits of 1010.
    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

endpackage

// File: rtl/seq_det_core.sv
// Overlapping 1010 Mealy detector with a loadable state register.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       x,
    input  logic       ld,
    input  logic [1:0] ld_state,
    output logic       match,
    output logic [1:0] state
);

    logic [1:0] nxt;

    always_comb begin
        nxt = S0;
        case (state)
            S0:      nxt = x ? S1 : S0;
            S1:      nxt = x ? S1 : S2;
            S2:      nxt = x ? S3 : S0;
            S3:      nxt = x ? S1 : S2;
            default: nxt = S0;
        endcase
    end

    assign match = en && (state == S3) && !x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S0;
        else if (ld)
            state <= ld_state;
        else if (en)
            state <= nxt;
    end

endmodule

// File: rtl/seq_det_arb.sv
// Two-requester round-robin front end feeding words MSB-first into seq_det_core.
// Define SEQ_DET_ARB_CTX_EN to keep a per-requester detector context across words.
module seq_det_arb
    import seq_det_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
    output logic [1:0]   ack,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic [3:0]   match_cnt,
    output logic         match,
    output logic [1:0]   det_state
);

    ctrl_state_t  st;
    logic         id;
    logic         last;
    logic         gnt;
    logic [3:0]   bitcnt;
    logic [3:0]   cnt;
    logic [W-1:0] shreg;
    logic [1:0]   ld_state;
    logic         shift_en;
    logic         load_en;

    // With both requesting, the one not served last wins.
    assign gnt      = (req == 2'b11) ? ~last : req[1];
    assign shift_en = (st == SHIFT);
    assign load_en  = (st == LOAD);

`ifdef SEQ_DET_ARB_CTX_EN
    logic [1:0] ctx0;
    logic [1:0] ctx1;

    assign ld_state = id ? ctx1 : ctx0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx0 <= S0;
            ctx1 <= S0;
        end else if (st == DONE) begin
            if (id)
                ctx1 <= det_state;
            else
                ctx0 <= det_state;
        end
    end
`else
    assign ld_state = S0;
`endif

    // Word is latched on the grant edge, so it is safe once ack is visible.
    always_ff @(posedge clk) begin
        if (st == IDLE && req != 2'b00)
            shreg <= gnt ? data1 : data0;
        else if (shift_en)
            shreg <= {shreg[W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            id        <= 1'b0;
            last      <= 1'b1;
            bitcnt    <= 4'd0;
            cnt       <= 4'd0;
            ack       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            match_cnt <= 4'd0;
        end else begin
            ack  <= 2'b00;
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (req != 2'b00) begin
                        st   <= LOAD;
                        id   <= gnt;
                        ack  <= gnt ? 2'b10 : 2'b01;
                        busy <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt    <= 4'd0;
                    bitcnt <= 4'd0;
                    st     <= SHIFT;
                end
                SHIFT: begin
                    cnt    <= cnt + {3'b000, match};
                    bitcnt <= bitcnt + 4'd1;
                    if (bitcnt == 4'(W - 1)) begin
                        st        <= DONE;
                        done      <= 1'b1;
                        done_id   <= id;
                        match_cnt <= cnt + {3'b000, match};
                    end
                end
                DONE: begin
                    last <= id;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    seq_det_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (shift_en),
        .x        (shreg[W-1]),
        .ld       (load_en),
        .ld_state (ld_state),
        .match    (match),
        .state    (det_state)
    );

endmodule

// File: tb/tb_seq_det_arb.sv
// Scoreboard bench for seq_det_arb: driver predicts each word's result from a bit-history model.
module tb_seq_det_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic [1:0]   ack;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [3:0]   match_cnt;
    logic         match;
    logic [1:0]   det_state;

    seq_det_arb #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt),
        .match     (match),
        .det_state (det_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic [3:0] cnt;
        logic [1:0] st;
        int         t;
    } exp_t;

    exp_t         sb[$];
    bit           hist0[$];
    bit           hist1[$];
    logic         last_m;
    logic [1:0]   pending;
    logic [W-1:0] dat[2];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = {(W/2){2'b10}};
            2:       r = '1;
            default: r = W'($urandom);
        endcase
        return r;
    endfunction

    // Count 1010 occurrences ending inside the new word; result state = longest
    // suffix of the bit history that is a proper prefix of 1010.
    task automatic model(input logic who, input logic [W-1:0] w,
                         output logic [3:0] c, output logic [1:0] s);
        bit q[$];
        int n;
`ifdef SEQ_DET_ARB_CTX_EN
        if (who) q = hist1;
        else     q = hist0;
`endif
        c = 4'd0;
        for (int b = W - 1; b >= 0; b--) begin
            q.push_back(w[b]);
            n = q.size();
            if (n >= 4 && q[n-4] == 1 && q[n-3] == 0 && q[n-2] == 1 && q[n-1] == 0)
                c = c + 4'd1;
        end
        n = q.size();
        s = 2'd0;
        if (n >= 3 && q[n-3] == 1 && q[n-2] == 0 && q[n-1] == 1)
            s = 2'd3;
        else if (n >= 2 && q[n-2] == 1 && q[n-1] == 0)
            s = 2'd2;
        else if (n >= 1 && q[n-1] == 1)
            s = 2'd1;
        if (who) hist1 = q;
        else     hist0 = q;
    endtask

    task automatic do_txn(input bit hold, output logic won, output int t_ack, output int idle);
        logic win;
        int   n;
        exp_t e;
        if (pending == 2'b00)
            pending = 2'b01 << $urandom_range(0, 1);
        req   = pending;
        data0 = dat[0];
        data1 = dat[1];
        win   = (pending == 2'b11) ? ~last_m : pending[1];
        n     = 0;
        idle  = 0;
        do begin
            @(negedge clk);
            n++;
            if (!busy) idle++;
        end while (ack == 2'b00 && n < 60);
        won   = win;
        t_ack = cyc;
        if (ack == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout got 0 want %0h", win ? 2 : 1);
        end else begin
            chk("ack_grant", ack, win ? 2 : 1);
            e.id = win;
            model(win, dat[win], e.cnt, e.st);
            e.t = cyc;
            sb.push_back(e);
            last_m = win;
            if (!hold) begin
                pending[win] = 1'b0;
                req          = pending;
                dat[win]     = rnd_word();
                data0        = dat[0];
                data1        = dat[1];
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        hist0.delete();
        hist1.delete();
        last_m = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: pops on every done, and checks held outputs on all other cycles.
    initial begin
        exp_t       e;
        logic       last_id;
        logic [3:0] last_cnt;
        last_id  = 1'b0;
        last_cnt = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_id  = 1'b0;
                last_cnt = 4'd0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got done_id=%0d want no done", done_id);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("match_cnt", match_cnt, e.cnt);
                    chk("final_state", det_state, e.st);
                    chk("done_latency", cyc - e.t, W + 1);
                    last_id  = e.id;
                    last_cnt = e.cnt;
                end
            end else begin
                chk("hold_done_id", done_id, last_id);
                chk("hold_match_cnt", match_cnt, last_cnt);
                if (!busy) chk("match_idle", match, 0);
            end
        end
    end

    initial begin
        logic won;
        int   t, idle, prev_t, n, seen;
        dat[0]  = rnd_word();
        dat[1]  = rnd_word();
        pending = 2'b00;
        last_m  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_match", match, 0);
        chk("rst_det_state", det_state, 0);
        #2 rst_n = 1'b1;

        // Alternating word, then one whose count depends on carried context.
        dat[0] = 8'b10101010; pending = 2'b01;
        do_txn(1'b0, won, t, idle);
        dat[0] = 8'b10100000; pending = 2'b01;
        do_txn(1'b0, won, t, idle);
        drain();

        // Both requesting from reset: strict alternation starting with 0.
        do_reset();
        pending = 2'b11;
        for (int k = 0; k < 4; k++) begin
            do_txn(1'b0, won, t, idle);
            chk("rr_order", won, k % 2);
            pending = 2'b11;
        end
        do_txn(1'b0, won, t, idle);
        drain();

        // All-zero word from requester 1.
        dat[1] = '0; pending = 2'b10;
        do_txn(1'b0, won, t, idle);
        seen = 0;
        n    = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (match) seen++;
        end
        chk("zero_word_match_seen", seen, 0);
        drain();

        // Reset during the fourth SHIFT cycle aborts the word.
        dat[0] = 8'b10101010; pending = 2'b01;
        do_txn(1'b0, won, t, idle);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_match", match, 0);
        chk("abort_det_state", det_state, 0);
        chk("abort_done", done, 0);
        void'(sb.pop_back());
        hist0.delete();
        hist1.delete();
        last_m = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        dat[0] = 8'b01010000; pending = 2'b01;
        do_txn(1'b0, won, t, idle);
        drain();

        // Requester 0 held continuously: fixed service period, one idle cycle.
        dat[0] = rnd_word(); pending = 2'b01;
        do_txn(1'b1, won, prev_t, idle);
        for (int k = 0; k < 3; k++) begin
            do_txn(1'b1, won, t, idle);
            chk("held_period", t - prev_t, W + 3);
            chk("held_idle_cycles", idle, 1);
            prev_t = t;
        end
        pending = 2'b00;
        req     = 2'b00;
        drain();

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++)
                if (!pending[i] && $urandom_range(0, 1) == 1) pending[i] = 1'b1;
            do_txn(1'b0, won, t, idle);
        end
        while (pending != 2'b00) do_txn(1'b0, won, t, idle);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_arb.md
SEQ_DET_ARB -- requirements
Module: seq_det_arb

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the word width in bits; legal range 4..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 2 bits: per-requester word request, held high until the matching ack.
REQ-005 The block SHALL have ports data0 and data1, input, W bits each: the words of requester 0 and requester 1, held stable while the matching req is high.
REQ-006 The block SHALL have port ack, output, 2 bits: one-cycle pulse to the requester whose word was captured.
REQ-007 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-009 The block SHALL have port done_id, output, 1 bit: the requester that owns the result.
REQ-010 The block SHALL have port match_cnt, output, 4 bits: the number of 1010 matches in the finished word.
REQ-011 The block SHALL have port match, output, 1 bit: live Mealy detector output; it SHALL be low outside SHIFT.
REQ-012 The block SHALL have port det_state, output, 2 bits: the current detector state (S0=00, S1=01, S2=10, S3=11).

Function
REQ-013 The controller FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-014 IDLE: with any req high, the FSM SHALL grant one requester and go to LOAD; with no req high, it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin using a last-served pointer.
- With both req high, the requester not served last SHALL win.
- With a single req high, that requester SHALL always win.
REQ-016 LOAD (1 cycle): the block SHALL capture the granted word, assert ack[id] for that cycle, clear the match counter, load the detector state from the granted requester's context, then go to SHIFT.
REQ-017 SHIFT (W cycles): the block SHALL feed the word into the detector MSB-first, one bit per cycle.
REQ-018 Detector transitions SHALL be Mealy, with match=1 only on S3 with x=0:
- S0: x=1 -> S1; x=0 -> S0.
- S1: x=0 -> S2; x=1 -> S1.
- S2: x=1 -> S3; x=0 -> S0.
- S3: x=0 -> S2 with match=1; x=1 -> S1.
REQ-019 Overlapping matches SHALL count; match_cnt SHALL increment by 1 on each cycle in which match=1.
REQ-020 DONE (1 cycle): the block SHALL assert done with done_id and match_cnt valid, write the detector state back to the owner's context, update the last-served pointer, then return to IDLE.
REQ-021 The service period SHALL be W+3 cycles: LOAD to the next possible LOAD with req held continuously is 11 cycles for W=8.
REQ-022 A req deasserting after ack SHALL have no effect on the word in flight.
REQ-023 A req still high in IDLE after its ack SHALL be treated as a new word.
REQ-024 match_cnt and done_id SHALL hold their last values between done pulses.
REQ-025 An unused det_state encoding SHALL NOT exist: all four states are legal, and the default branch SHALL go to S0.

Reset
REQ-026 Asserting rst_n low SHALL take effect immediately, including mid-SHIFT, and the aborted word SHALL produce no done.
REQ-027 Reset SHALL set: FSM=IDLE, both contexts=S0, last-served=1 (requester 0 first).
REQ-028 Reset SHALL drive the outputs to: ack=00, busy=0, done=0, done_id=0, match_cnt=0, match=0, det_state=00.

Configuration
REQ-029 The macro SEQ_DET_ARB_CTX_EN SHALL control context handling.
- Defined: each requester SHALL keep its own 2-bit context, so patterns spanning consecutive words of the same requester SHALL be detected.
- Undefined: the context registers SHALL be absent, and LOAD SHALL always start the detector at S0.

Structure
REQ-030 Package seq_det_pkg SHALL hold:
- the controller state enum;
- the detector state constants S0..S3;
- the default of W.
REQ-031 The detector SHALL be a sub-module seq_det_core with ports:
- inputs: clk, rst_n, en, x, ld, ld_state;
- outputs: match, state.
REQ-032 Arbitration, sequencing, counting and contexts SHALL reside in seq_det_arb.

Verification
REQ-033 Scenario: req=01, data0=8'b10101010 -> ack=01 in the LOAD cycle, done 9 cycles later with done_id=0 and match_cnt=3; context0 is S2.
REQ-034 Scenario: follow REQ-033 with data0=8'b10100000.
- With SEQ_DET_ARB_CTX_EN: match_cnt=2.
- Without it: match_cnt=1.
REQ-035 Scenario: req=11 from reset -> requester 0 is served first, then requester 1; done_id sequence is 0,1, and done_id alternates while both requests stay high.
REQ-036 Scenario: data1=8'h00 -> done with done_id=1, match_cnt=0, and match never high.
REQ-037 Scenario: rst_n low during the 4th SHIFT cycle -> same cycle busy=0, match=0, det_state=00; no done follows; the next word starts from S0.
REQ-038 Scenario: req0 held high -> ack[0] pulses every 11 cycles (W=8); busy is low for exactly 1 cycle between words.
